// File: rtl/drv_adc_pkg.sv
// Shared types and constants for the simultaneous-sampling SAR ADC driver:
// FSM state encoding, SCK divisor encoding/increment lookup and power-on timing defaults.
package drv_adc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CNV,
    ST_WAIT_CNV,
    ST_WAIT_CONV,
    ST_RECV,
    ST_HANG
  } state_t;

  typedef enum logic [1:0] {
    DIV_2  = 2'd0,
    DIV_4  = 2'd1,
    DIV_8  = 2'd2,
    DIV_16 = 2'd3
  } clkdiv_t;

  localparam int unsigned T_CNV_DEF  = 6;
  localparam int unsigned T_CONV_DEF = 90;
  localparam int unsigned T_HANG_DEF = 200;

  // Phase-accumulator step; SCK period is 16/step clk cycles.
  function automatic logic [3:0] sck_inc(input clkdiv_t div);
    case (div)
      DIV_2:   return 4'd8;
      DIV_4:   return 4'd4;
      DIV_8:   return 4'd2;
      default: return 4'd1;
    endcase
  endfunction

endpackage

// File: rtl/adc_sck_gen.sv
// SCK generator: 4-bit phase accumulator, SCK = acc[3], and a capture strobe on the
// last clk before each SCK falling edge. Held at zero phase while disabled.
module adc_sck_gen
  import drv_adc_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    en,
  input  clkdiv_t clkdiv,
  output logic    sck,
  output logic    cap_stb
);

  logic [3:0] acc;
  logic [3:0] inc;
  logic [3:0] cap_val;

  assign inc     = sck_inc(clkdiv);
  // 16 - inc in 4-bit arithmetic: the phase just before the accumulator wraps.
  assign cap_val = 4'd0 - inc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   acc <= '0;
    else if (!en) acc <= '0;
    else          acc <= acc + inc;
  end

  assign sck     = en & acc[3];
  assign cap_stb = en & (acc == cap_val);

endmodule

// File: rtl/drv_adc_simul_sar.sv
// Driver for simultaneous-sampling serial SAR ADCs (LTC2320 family), one SDO lane per channel.
// Define DRV_ADC_SIMUL_SAR_AVG_EN to add N-frame averaging (N = 2**avg_log2).
module drv_adc_simul_sar
  import drv_adc_pkg::*;
#(
  parameter int NUM_CH    = 8,
  parameter int RAW_BITS  = 16,
  parameter int DATA_BITS = 14,
  parameter int DLY_W     = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          trigger,
  input  logic                          cont_en,
  input  logic [1:0]                    clkdiv,
  input  logic [DLY_W-1:0]              t_cnv,
  input  logic [DLY_W-1:0]              t_conv,
  input  logic [DLY_W-1:0]              t_hang,
`ifdef DRV_ADC_SIMUL_SAR_AVG_EN
  input  logic [1:0]                    avg_log2,
`endif
  output logic                          CNV_n,
  output logic                          SCK,
  input  logic [NUM_CH-1:0]             SDO,
  output logic [NUM_CH*DATA_BITS-1:0]   data,
  output logic                          data_valid,
  output logic                          sample_stb,
  output logic                          adc_done,
  output logic                          busy,
  output logic [31:0]                   conv_count
);

  localparam int BCNT_W = $clog2(RAW_BITS + 1);

  state_t              state, state_nxt;
  clkdiv_t             div_s;
  logic [DLY_W-1:0]    t_cnv_s, t_conv_s, t_hang_s, t_sel, dly;
  logic [DLY_W:0]      elapsed;
  logic [BCNT_W-1:0]   bit_cnt;
  logic [RAW_BITS-1:0] shreg     [NUM_CH];
  logic [RAW_BITS-1:0] shreg_nxt [NUM_CH];
  logic [DATA_BITS-1:0] result   [NUM_CH];
  logic sck_en, cap_stb, timer_hit, frame_end, relatch;
  logic burst_first, burst_last, burst_pending;

`ifdef DRV_ADC_SIMUL_SAR_AVG_EN
  localparam int ACC_W = DATA_BITS + 3;
  logic [1:0]              avg_s;
  logic [2:0]              avg_cnt;
  logic signed [ACC_W-1:0] sum     [NUM_CH];
  logic signed [ACC_W-1:0] sum_nxt [NUM_CH];

  function automatic logic signed [ACC_W-1:0] sext(input logic [DATA_BITS-1:0] s);
    return {{3{s[DATA_BITS-1]}}, s};
  endfunction

  function automatic logic [DATA_BITS-1:0] avg_scale(input logic signed [ACC_W-1:0] s,
                                                     input logic [1:0] sh);
    logic signed [ACC_W-1:0] q;
    q = s >>> sh;
    return q[DATA_BITS-1:0];
  endfunction

  assign burst_first   = (avg_cnt == 3'd0);
  assign burst_last    = (avg_cnt == ~(3'b111 << avg_s));
  assign burst_pending = (avg_cnt != 3'd0);
`else
  assign burst_first   = 1'b1;
  assign burst_last    = 1'b1;
  assign burst_pending = 1'b0;
`endif

  assign sck_en = (state == ST_RECV);
  assign busy   = (state != ST_IDLE);

  adc_sck_gen u_sck_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (sck_en),
    .clkdiv  (div_s),
    .sck     (SCK),
    .cap_stb (cap_stb)
  );

  // Every timed state lasts max(t,1) cycles: elapsed counts cycles spent so far.
  always_comb begin
    t_sel = t_hang_s;
    if (state == ST_WAIT_CNV)       t_sel = t_cnv_s;
    else if (state == ST_WAIT_CONV) t_sel = t_conv_s;
  end

  assign elapsed   = {1'b0, dly} + {{DLY_W{1'b0}}, 1'b1};
  assign timer_hit = (elapsed >= {1'b0, t_sel});
  assign frame_end = sck_en && cap_stb && (bit_cnt == BCNT_W'(RAW_BITS - 1));
  assign relatch   = ((state == ST_IDLE) && (trigger || cont_en)) ||
                     ((state == ST_HANG) && timer_hit && cont_en && !burst_pending);

  always_comb begin
    for (int ch = 0; ch < NUM_CH; ch++) begin
      shreg_nxt[ch] = {shreg[ch][RAW_BITS-2:0], SDO[ch]};
`ifdef DRV_ADC_SIMUL_SAR_AVG_EN
      sum_nxt[ch] = (burst_first ? '0 : sum[ch]) + sext(shreg_nxt[ch][RAW_BITS-1 -: DATA_BITS]);
      result[ch]  = avg_scale(sum_nxt[ch], avg_s);
`else
      result[ch]  = shreg_nxt[ch][RAW_BITS-1 -: DATA_BITS];
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:      if (trigger || cont_en) state_nxt = ST_CNV;
      ST_CNV:       state_nxt = ST_WAIT_CNV;
      ST_WAIT_CNV:  if (timer_hit) state_nxt = ST_WAIT_CONV;
      ST_WAIT_CONV: if (timer_hit) state_nxt = ST_RECV;
      ST_RECV:      if (frame_end) state_nxt = ST_HANG;
      ST_HANG:      if (timer_hit) state_nxt = (cont_en || burst_pending) ? ST_CNV : ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_s      <= DIV_2;
      t_cnv_s    <= DLY_W'(T_CNV_DEF);
      t_conv_s   <= DLY_W'(T_CONV_DEF);
      t_hang_s   <= DLY_W'(T_HANG_DEF);
      dly        <= '0;
      bit_cnt    <= '0;
      CNV_n      <= 1'b0;
      data       <= '0;
      data_valid <= 1'b0;
      sample_stb <= 1'b0;
      adc_done   <= 1'b1;
      conv_count <= '0;
      for (int ch = 0; ch < NUM_CH; ch++) shreg[ch] <= '0;
`ifdef DRV_ADC_SIMUL_SAR_AVG_EN
      avg_s   <= '0;
      avg_cnt <= '0;
      for (int ch = 0; ch < NUM_CH; ch++) sum[ch] <= '0;
`endif
    end else begin
      sample_stb <= 1'b0;
      if (relatch) begin
        div_s    <= clkdiv_t'(clkdiv);
        t_cnv_s  <= t_cnv;
        t_conv_s <= t_conv;
        t_hang_s <= t_hang;
`ifdef DRV_ADC_SIMUL_SAR_AVG_EN
        avg_s    <= avg_log2;
`endif
        adc_done <= 1'b0;
      end
      case (state)
        ST_CNV: begin
          CNV_n <= 1'b1;
          dly   <= '0;
        end
        ST_WAIT_CNV, ST_WAIT_CONV, ST_HANG: begin
          dly <= timer_hit ? '0 : elapsed[DLY_W-1:0];
          if (state == ST_WAIT_CNV && timer_hit) CNV_n <= 1'b0;
          if (state == ST_WAIT_CONV && timer_hit) begin
            bit_cnt <= '0;
            if (burst_first) data_valid <= 1'b0;
          end
        end
        ST_RECV: if (cap_stb) begin
          for (int ch = 0; ch < NUM_CH; ch++) shreg[ch] <= shreg_nxt[ch];
          bit_cnt <= bit_cnt + BCNT_W'(1);
          if (frame_end) begin
            dly <= '0;
`ifdef DRV_ADC_SIMUL_SAR_AVG_EN
            for (int ch = 0; ch < NUM_CH; ch++) sum[ch] <= sum_nxt[ch];
            avg_cnt <= burst_last ? 3'd0 : avg_cnt + 3'd1;
`endif
            // Results and status move only once the whole (averaged) sample is complete.
            if (burst_last) begin
              for (int ch = 0; ch < NUM_CH; ch++) data[ch*DATA_BITS +: DATA_BITS] <= result[ch];
              data_valid <= 1'b1;
              sample_stb <= 1'b1;
              adc_done   <= 1'b1;
              conv_count <= conv_count + 32'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_drv_adc_simul_sar.sv
// Self-checking bench for drv_adc_simul_sar: a behavioural ADC drives SDO per SCK edge,
// and frame timing/results are compared against values derived from the frame rules.
module tb_drv_adc_simul_sar;

  localparam int NUM_CH    = 8;
  localparam int RAW_BITS  = 16;
  localparam int DATA_BITS = 14;
  localparam int DLY_W     = 8;

  logic clk = 1'b0;
  logic rst_n, trigger, cont_en;
  logic [1:0] clkdiv;
  logic [DLY_W-1:0] t_cnv, t_conv, t_hang;
  logic CNV_n, SCK, data_valid, sample_stb, adc_done, busy;
  logic [NUM_CH-1:0] SDO;
  logic [NUM_CH*DATA_BITS-1:0] data;
  logic [31:0] conv_count;
`ifdef DRV_ADC_SIMUL_SAR_AVG_EN
  logic [1:0] avg_log2 = 2'd0;
`endif

  logic [RAW_BITS-1:0] pat [NUM_CH];
  int bitidx = 99;
  logic cnv_prev_b = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  int cyc = 0, stb_cnt = 0, cnv_hi = 0, cnv_hi_len = 0, sck_rises = 0;
  int sck_per = 0, last_rise = 0, done_bad = 0;
  int cnv_rise [$];
  logic cnv_q = 1'b0, sck_q = 1'b0;

  drv_adc_simul_sar #(
    .NUM_CH(NUM_CH), .RAW_BITS(RAW_BITS), .DATA_BITS(DATA_BITS), .DLY_W(DLY_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .trigger(trigger), .cont_en(cont_en), .clkdiv(clkdiv),
    .t_cnv(t_cnv), .t_conv(t_conv), .t_hang(t_hang),
`ifdef DRV_ADC_SIMUL_SAR_AVG_EN
    .avg_log2(avg_log2),
`endif
    .CNV_n(CNV_n), .SCK(SCK), .SDO(SDO), .data(data), .data_valid(data_valid),
    .sample_stb(sample_stb), .adc_done(adc_done), .busy(busy), .conv_count(conv_count)
  );

  initial forever #5 clk = ~clk;

  // ADC model: MSB presented after CNV_n rises, next bit after every SCK falling edge.
  initial forever begin
    @(negedge SCK or posedge CNV_n);
    if (CNV_n && !cnv_prev_b) bitidx = 0;
    else bitidx++;
    cnv_prev_b = CNV_n;
  end

  always_comb begin
    logic [RAW_BITS-1:0] tmp;
    SDO = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      tmp = pat[i] << bitidx;
      SDO[i] = tmp[RAW_BITS-1];
    end
  end

  // Pin-level observer, sampled on the inactive clock edge.
  initial forever begin
    @(negedge clk);
    cyc++;
    if (CNV_n && !cnv_q) begin
      cnv_rise.push_back(cyc);
      cnv_hi = 0;
      sck_rises = 0;
    end
    if (CNV_n) cnv_hi++;
    else if (cnv_q) cnv_hi_len = cnv_hi;
    if (SCK && !sck_q) begin
      sck_rises++;
      if (sck_rises > 1) sck_per = cyc - last_rise;
      last_rise = cyc;
    end
    if (sample_stb) stb_cnt++;
    if ((CNV_n || SCK) && adc_done) done_bad++;
    cnv_q = CNV_n;
    sck_q = SCK;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int max1(input logic [DLY_W-1:0] t);
    return (t == '0) ? 1 : int'(t);
  endfunction

  task automatic pulse_trigger();
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
  endtask

  task automatic wait_stb(input string tag, input int budget);
    int n = 0;
    tick();
    while (!sample_stb && n < budget) begin
      tick();
      n++;
    end
    chk(tag, 64'(sample_stb), 64'd1);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    chk(tag, 64'(busy), 64'd0);
  endtask

  task automatic check_reset(input string pre);
    chk({pre, "_cnv"},   64'(CNV_n), 64'd0);
    chk({pre, "_sck"},   64'(SCK), 64'd0);
    chk({pre, "_data0"}, 64'(data == '0), 64'd1);
    chk({pre, "_valid"}, 64'(data_valid), 64'd0);
    chk({pre, "_stb"},   64'(sample_stb), 64'd0);
    chk({pre, "_done"},  64'(adc_done), 64'd1);
    chk({pre, "_busy"},  64'(busy), 64'd0);
    chk({pre, "_count"}, 64'(conv_count), 64'd0);
  endtask

  task automatic check_frame(input string pre, input int period, input int cnv_len);
    for (int ch = 0; ch < NUM_CH; ch++)
      chk($sformatf("%s_data%0d", pre, ch), 64'(data[ch*DATA_BITS +: DATA_BITS]),
          64'(pat[ch] >> (RAW_BITS - DATA_BITS)));
    chk({pre, "_sckper"}, 64'(sck_per), 64'(period));
    chk({pre, "_nsck"},   64'(sck_rises), 64'(RAW_BITS));
    chk({pre, "_cnvhi"},  64'(cnv_hi_len), 64'(cnv_len));
    chk({pre, "_valid"},  64'(data_valid), 64'd1);
  endtask

  task automatic random_pats();
    for (int i = 0; i < NUM_CH; i++) pat[i] = RAW_BITS'($urandom);
  endtask

  initial begin
    int base, d, frame_len;
    logic [31:0] cnt0;
    rst_n = 1'b0; trigger = 1'b0; cont_en = 1'b0; clkdiv = 2'd0;
    t_cnv = 8'd6; t_conv = 8'd90; t_hang = 8'd200;
    for (int i = 0; i < NUM_CH; i++) pat[i] = '0;
    repeat (3) tick();
    check_reset("rst");
    rst_n = 1'b1;
    tick();

    // Single frame, default timing, /2
    random_pats();
    pat[0] = 16'hA5C3;
    base = stb_cnt;
    pulse_trigger();
    wait_stb("A_stb", 2000);
    check_frame("A", 2, 6);
    chk("A_count", 64'(conv_count), 64'd1);
    wait_idle("A_idle", 1000);
    chk("A_pulses", 64'(stb_cnt - base), 64'd1);
    chk("A_done", 64'(adc_done), 64'd1);

    // /16, constant per-lane words, random short timing
    clkdiv = 2'd3;
    t_cnv = 8'($urandom_range(0, 10)); t_conv = 8'($urandom_range(0, 20));
    t_hang = 8'($urandom_range(0, 10));
    for (int i = 0; i < NUM_CH; i++) pat[i] = 16'h1234 + 16'(i);
    base = done_bad;
    pulse_trigger();
    wait_stb("B_stb", 4000);
    check_frame("B", 16, max1(t_cnv));
    chk("B_done_low", 64'(done_bad - base), 64'd0);
    chk("B_count", 64'(conv_count), 64'd2);
    wait_idle("B_idle", 1000);

    // Free-running, /4: fixed CNV-to-CNV spacing, stops cleanly
    clkdiv = 2'd1;
    t_cnv = 8'($urandom_range(0, 12)); t_conv = 8'($urandom_range(0, 12));
    t_hang = 8'($urandom_range(0, 12));
    frame_len = 1 + max1(t_cnv) + max1(t_conv) + RAW_BITS * 4 + max1(t_hang);
    random_pats();
    cnv_rise.delete();
    base = stb_cnt;
    cont_en = 1'b1;
    for (int k = 0; k < 3; k++) wait_stb($sformatf("C_stb%0d", k), 2000);
    cont_en = 1'b0;
    wait_idle("C_idle", 2000);
    repeat (5) tick();
    d = stb_cnt - base;
    chk("C_stays_idle", 64'(busy), 64'd0);
    chk("C_frames", 64'((d == 3) || (d == 4)), 64'd1);
    chk("C_count", 64'(conv_count), 64'(2 + d));
    chk("C_ncnv", 64'(cnv_rise.size()), 64'(d));
    chk("C_done", 64'(adc_done), 64'd1);
    for (int k = 1; k < cnv_rise.size(); k++)
      chk($sformatf("C_gap%0d", k), 64'(cnv_rise[k] - cnv_rise[k-1]), 64'(frame_len));
    check_frame("C", 4, max1(t_cnv));

    // Reset in the middle of RECV, then a clean frame
    clkdiv = 2'd0; t_cnv = 8'd6; t_conv = 8'd90; t_hang = 8'd200;
    random_pats();
    pulse_trigger();
    begin
      int n = 0;
      while (bitidx != 7 && n < 2000) begin
        tick();
        n++;
      end
    end
    chk("D_bit7", 64'(bitidx), 64'd7);
    chk("D_in_recv", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check_reset("D_rst");
    tick();
    rst_n = 1'b1;
    tick();
    random_pats();
    base = stb_cnt;
    pulse_trigger();
    wait_stb("D_stb", 2000);
    check_frame("D", 2, 6);
    chk("D_count", 64'(conv_count), 64'd1);
    wait_idle("D_idle", 1000);
    chk("D_pulses", 64'(stb_cnt - base), 64'd1);

    // Config change mid-frame and trigger during HANG
    clkdiv = 2'd0; t_cnv = 8'd6; t_conv = 8'd20; t_hang = 8'd30;
    random_pats();
    cnt0 = conv_count;
    pulse_trigger();
    begin
      int n = 0;
      while (!SCK && n < 500) begin
        tick();
        n++;
      end
    end
    chk("E_sck_seen", 64'(SCK), 64'd1);
    clkdiv = 2'd2;
    wait_stb("E1_stb", 2000);
    check_frame("E1", 2, 6);
    chk("E_busy_hang", 64'(busy), 64'd1);
    base = stb_cnt;
    pulse_trigger();
    wait_idle("E_idle", 1000);
    repeat (5) tick();
    chk("E_trig_ignored", 64'(busy), 64'd0);
    chk("E_count1", 64'(conv_count), 64'(cnt0 + 32'd1));
    chk("E_no_extra", 64'(stb_cnt - base), 64'd0);
    random_pats();
    pulse_trigger();
    wait_stb("E2_stb", 2000);
    check_frame("E2", 8, 6);
    chk("E_count2", 64'(conv_count), 64'(cnt0 + 32'd2));
    wait_idle("E2_idle", 1000);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
